// File: rtl/seq_det_ctrl.sv
// Sequencer for a serial "1101" Mealy detector: accepts a parallel word, optionally
// clears the detector, shifts the word in MSB-first and reports the hit statistics.
//
// state | meaning
// IDLE  | ready for a word, results from the last word held
// CLR   | one-cycle synchronous clear of the detector
// SHIFT | one word bit per cycle into the detector, hits counted
// DONE  | one-cycle done pulse, results valid
module seq_det_ctrl #(
  parameter int WORD_W = 8,
  parameter int POS_W  = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              keep_ctx,
  output logic              in_ready,
  output logic              det_en,
  output logic              det_din,
  output logic              det_clr,
  input  logic              det_dout,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [POS_W-1:0]  first_pos,
  output logic              hit
);

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [POS_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]    first_q, first_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    in_ready = 1'b0;
    det_en   = 1'b0;
    det_din  = 1'b0;
    det_clr  = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          cnt_d   = '0;
          first_d = '0;
          idx_d   = '0;
          state_d = keep_ctx ? SHIFT : CLR;
        end
      end
      CLR: begin
        det_clr = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        // The word register shifts left, so its MSB is always the current bit.
        det_en  = 1'b1;
        det_din = word_q[WORD_W-1];
        word_d  = {word_q[WORD_W-2:0], 1'b0};
        idx_d   = idx_q + POS_W'(1);
        if (det_dout) begin
          if (cnt_q == '0) first_d = idx_q;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign match_cnt = cnt_q;
  assign first_pos = first_q;
  assign hit       = (cnt_q != '0);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: two instances (CNT_W=4 and CNT_W=1) each driving its own
// "1101" detector, checked every cycle against a bit-history model.
module tb_seq_det_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, keep_ctx;
  logic [W-1:0] in_data;

  logic       ready_a, en_a, din_a, clr_a, dout_a, done_a, hit_a;
  logic [3:0] cnt_a;
  logic [2:0] pos_a;
  logic       ready_b, en_b, din_b, clr_b, dout_b, done_b, hit_b;
  logic [0:0] cnt_b;
  logic [2:0] pos_b;

  seq_det_ctrl #(.WORD_W(W), .POS_W(3), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .keep_ctx(keep_ctx),
    .in_ready(ready_a), .det_en(en_a), .det_din(din_a), .det_clr(clr_a), .det_dout(dout_a),
    .done(done_a), .match_cnt(cnt_a), .first_pos(pos_a), .hit(hit_a));

  seq_det_ctrl #(.WORD_W(W), .POS_W(3), .CNT_W(1)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .keep_ctx(keep_ctx),
    .in_ready(ready_b), .det_en(en_b), .det_din(din_b), .det_clr(clr_b), .det_dout(dout_b),
    .done(done_b), .match_cnt(cnt_b), .first_pos(pos_b), .hit(hit_b));

  // Detectors: last three bits since clear; a 1 after "110" completes "1101".
  logic [2:0] ha = '0, hb = '0;
  assign dout_a = en_a && din_a && (ha == 3'b110);
  assign dout_b = en_b && din_b && (hb == 3'b110);
  always @(posedge clk) begin
    if (reset || clr_a) ha <= '0; else if (en_a) ha <= {ha[1:0], din_a};
    if (reset || clr_b) hb <= '0; else if (en_b) hb <= {hb[1:0], din_b};
  end

  int n_pass = 0, n_total = 0;
  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: cycle index, accept cycle, and the bit history seen by the detector.
  int       cyc = 0;
  bit       m_ok = 0, active = 0, m_clr = 0;
  int       acc = 0;
  logic [W-1:0] m_word;
  bit       hits [W];
  bit       ctx [$];
  bit       e_ready, e_en, e_din, e_clr, e_done;
  int       e_cnt, e_first;

  task model_expect();
    int k, off, n;
    e_ready = 1; e_en = 0; e_din = 0; e_clr = 0; e_done = 0; e_cnt = 0; e_first = 0;
    if (active) begin
      k = cyc - acc;
      off = m_clr ? 1 : 0;
      e_ready = 0;
      if (k < off) begin
        e_clr = 1; n = 0;
      end else if (k < off + W) begin
        n = k - off; e_en = 1; e_din = m_word[W-1-n];
      end else begin
        n = W;
        if (k == off + W) e_done = 1; else e_ready = 1;
      end
      for (int i = 0; i < n; i++)
        if (hits[i]) begin
          if (e_cnt == 0) e_first = i;
          e_cnt++;
        end
    end
  endtask

  always @(posedge clk) begin
    model_expect();
    if (reset) begin
      active = 0; ctx.delete(); m_ok = 1;
    end else if (m_ok && e_ready && in_valid) begin
      int s;
      active = 1; acc = cyc + 1; m_clr = !keep_ctx; m_word = in_data;
      if (m_clr) ctx.delete();
      for (int i = 0; i < W; i++) begin
        ctx.push_back(m_word[W-1-i]);
        s = ctx.size();
        hits[i] = (s >= 4) && ctx[s-4] && ctx[s-3] && !ctx[s-2] && ctx[s-1];
      end
    end
    cyc++;
  end

  int clr_seen = 0, done_seen = 0;
  always @(negedge clk) begin
    if (m_ok) begin
      model_expect();
      chk("in_ready", ready_a, e_ready);
      chk("det_en",   en_a,    e_en);
      chk("det_din",  din_a,   e_din);
      chk("det_clr",  clr_a,   e_clr);
      chk("done",     done_a,  e_done);
      chk("match_cnt", cnt_a,  e_cnt > 15 ? 15 : e_cnt);
      chk("first_pos", pos_a,  e_first);
      chk("hit",      hit_a,   e_cnt != 0);
      chk("sat_done", done_b,  e_done);
      chk("sat_cnt",  cnt_b,   e_cnt > 1 ? 1 : e_cnt);
      chk("sat_pos",  pos_b,   e_first);
      chk("sat_hit",  hit_b,   e_cnt != 0);
      if (clr_a) clr_seen++;
      if (done_a) done_seen++;
    end
  end

  // Offers a word and returns after the accepting edge.
  task automatic send(input logic [W-1:0] w, input bit keep);
    int t = 0;
    in_data = w; keep_ctx = keep; in_valid = 1;
    while (!ready_a && t < 50) begin @(posedge clk); #2; t++; end
    if (t >= 50) begin n_total++; $display("FAIL accept_timeout: waited %0d cycles", t); end
    @(posedge clk); #2;
    in_valid = 0;
  endtask

  // Returns the done latency relative to the first cycle after accept.
  task automatic wait_done(output int lat);
    int t = 0;
    @(negedge clk);
    while (!done_a && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin n_total++; $display("FAIL done_timeout: waited %0d cycles", t); end
    lat = cyc - acc;
  endtask

  initial begin
    int lat, a1, a2;
    reset = 1; in_valid = 0; keep_ctx = 0; in_data = '0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("rst_ready", ready_a, 1); chk("rst_done", done_a, 0); chk("rst_cnt", cnt_a, 0);
    chk("rst_pos", pos_a, 0); chk("rst_hit", hit_a, 0); chk("rst_en", en_a, 0);
    @(posedge clk); #2;

    // 1 & 4: overlapping hits at idx 3 and 6, saturation on the CNT_W=1 instance
    send(8'b11011011, 0); wait_done(lat);
    chk("t1_lat", lat, 9); chk("t1_cnt", cnt_a, 2); chk("t1_pos", pos_a, 3); chk("t1_hit", hit_a, 1);
    chk("t4_cnt", cnt_b, 1); chk("t4_pos", pos_b, 3);

    // 2: context carried across words only with keep_ctx
    send(8'b00000110, 0); wait_done(lat);
    chk("t2a_cnt", cnt_a, 0);
    send(8'b10000000, 1); wait_done(lat);
    chk("t2b_lat", lat, 8); chk("t2b_cnt", cnt_a, 1); chk("t2b_pos", pos_a, 0); chk("t2b_hit", hit_a, 1);
    send(8'b00000110, 0); wait_done(lat);
    send(8'b10000000, 0); wait_done(lat);
    chk("t2c_cnt", cnt_a, 0); chk("t2c_hit", hit_a, 0); chk("t2c_pos", pos_a, 0);

    // 3: in_valid held high, second word taken in the IDLE cycle after done
    @(posedge clk); #2;
    send(8'b01101101, 0); a1 = acc;
    in_data = 8'b11010000; in_valid = 1;
    send(8'b11010000, 0); a2 = acc;
    chk("t3_period", a2 - a1, 11);
    wait_done(lat);
    chk("t3_cnt", cnt_a, 1); chk("t3_pos", pos_a, 3);

    // 5: reset during SHIFT at idx 4 aborts the word
    @(posedge clk); #2;
    send(8'b11011011, 0);
    repeat (5) begin @(posedge clk); #2; end
    chk("t5_en_mid", en_a, 1); chk("t5_cnt_mid", cnt_a, 1);
    reset = 1;
    @(posedge clk); #2;
    reset = 0;
    done_seen = 0;
    chk("t5_ready", ready_a, 1); chk("t5_cnt", cnt_a, 0); chk("t5_pos", pos_a, 0);
    chk("t5_hit", hit_a, 0); chk("t5_en", en_a, 0);
    repeat (12) @(posedge clk);
    #2 chk("t5_no_done", done_seen, 0);

    // 6: all-zero word
    clr_seen = 0;
    send(8'b00000000, 0);
    wait_done(lat);
    chk("t6_lat", lat, 9); chk("t6_cnt", cnt_a, 0); chk("t6_hit", hit_a, 0);
    chk("t6_pos", pos_a, 0); chk("t6_clr", clr_seen, 1);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
